if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC, drives the instruction-memory address and registers the fetched word into ID.
- Consumes `stall` from the load-use hazard detector; that detector inspects `ID_inst` produced here.
- Consumes the redirect (branch taken / J / JAL / JR) resolved in ID, and keeps saturating stall/flush event counters for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_addr  out  32  instruction-memory address; equals the PC register.
- inst_data  in  32  instruction word. Memory is combinational-read: valid the same cycle as inst_addr.
- stall  in  1  load-use stall from hazard detector; hold PC and IF/ID.
- redirect_en  in  1  ID resolved a taken branch, J, JAL or JR.
- redirect_pc  in  32  target address for the redirect.
- ID_inst  out  32  registered instruction presented to ID.
- ID_pc  out  32  PC of ID_inst.
- ID_pcp4  out  32  ID_pc + 4, used for JAL link and branch-target add.
- ID_valid  out  1  1 = ID_inst is a real fetched instruction; 0 = bubble.
- stall_cnt  out  CNT_W  cycles with stall=1 since reset, saturating.
- flush_cnt  out  CNT_W  accepted redirects since reset, saturating.

Behaviour:
- Reset (rst=1 at edge), regardless of other inputs:
  - PC <= RESET_PC.
  - ID_inst <= 0, ID_pc <= 0, ID_pcp4 <= 0, ID_valid <= 0.
  - stall_cnt <= 0, flush_cnt <= 0.
- Reset mid-operation: a pending redirect or stall is discarded. The first fetch after rst deasserts is RESET_PC.
- inst_addr = PC at all times (combinational from register). Memory-to-ID latency is 1 cycle.
- No branch delay slot.
- Priority each edge (rst=0): stall > redirect > normal.
- Normal (stall=0, redirect_en=0):
  - PC <= PC + 4.
  - ID_inst <= inst_data, ID_pc <= PC, ID_pcp4 <= PC + 4, ID_valid <= 1.
- Redirect (stall=0, redirect_en=1):
  - PC <= redirect_pc.
  - IF/ID flushed: ID_inst <= 32'h0 (sll $0,$0,0 NOP), ID_valid <= 0, ID_pc/ID_pcp4 <= 0.
  - The word fetched this cycle (sequential successor) is squashed.
  - flush_cnt increments.
- Stall (stall=1):
  - PC, ID_inst, ID_pc, ID_pcp4 and ID_valid all hold.
  - redirect_en is ignored: the branch in ID is waiting on operands, so its redirect is not yet valid. ID must re-present it after the stall releases.
  - stall_cnt increments.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Arithmetic:
  - PC + 4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 silently.
  - redirect_pc is used as given; bits [1:0] are not checked or masked.
- A bubble (inst 0) reads only $0, so it never causes a hazard stall downstream.
- Back-to-back redirects are each accepted; each flushes and increments flush_cnt.
- Stall held N cycles holds state N cycles. The first non-stall edge resumes per priority.

Test Plan:
1. Reset then run: rst=1 for 2 cycles, inst_data = 32'h2008_0005 / 32'h2009_0003 at PCs 0/4.
   -> PC sequence 0,4,8; ID_inst 2008_0005 with ID_pc=0, ID_pcp4=4, then 2009_0003 with ID_pc=4; ID_valid=1 from the first edge after reset.
2. Load-use stall: stall=1 for 2 cycles with PC=8.
   -> inst_addr stays 8, ID outputs unchanged, stall_cnt=2; the next edge fetches 8, then 12.
3. Redirect: at PC=12, redirect_en=1, redirect_pc=32'h40.
   -> next edge PC=0x40, ID_inst=0, ID_valid=0, flush_cnt=1; the following edge gives ID_pc=0x40.
4. Stall and redirect together: stall=1, redirect_en=1, redirect_pc=0x80.
   -> PC and ID hold, flush_cnt unchanged, stall_cnt+1; then stall=0, redirect_en=1 -> PC=0x80.
5. Reset mid-operation: rst=1 while stall=1 and redirect_en=1.
   -> PC=RESET_PC, all ID outputs 0, both counters 0.
6. Saturation and wrap (CNT_W=2):
   - 5 stall cycles -> stall_cnt holds at 3.
   - Redirect to 32'hFFFF_FFFC then run -> next PC 0, ID_pcp4=0.

Source files
------------

// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: instruction fetch (PC owner) plus IF/ID pipeline register.
// Ports: clk/rst (sync, active-high); inst_addr/inst_data to combinational
// instruction memory; stall from load-use detector; redirect_en/redirect_pc
// from ID; ID_inst/ID_pc/ID_pcp4/ID_valid to ID; stall_cnt/flush_cnt are
// saturating debug event counters.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      inst_addr,
  input  logic [31:0]      inst_data,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      ID_inst,
  output logic [31:0]      ID_pc,
  output logic [31:0]      ID_pcp4,
  output logic             ID_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [31:0]      r_pc, r_id_inst, r_id_pc, r_id_pcp4;
  logic             r_id_valid;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic [31:0]      w_pc_p4;
  logic [CNT_W-1:0] w_stall_nxt, w_flush_nxt;
  assign w_pc_p4     = r_pc + 32'd4;
  assign w_stall_nxt = &r_stall_cnt ? r_stall_cnt : r_stall_cnt + CNT_W'(1);
  assign w_flush_nxt = &r_flush_cnt ? r_flush_cnt : r_flush_cnt + CNT_W'(1);
  // Stall outranks redirect: a branch waiting on operands has no valid target yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_id_inst   <= '0;
      r_id_pc     <= '0;
      r_id_pcp4   <= '0;
      r_id_valid  <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (stall) begin
      r_stall_cnt <= w_stall_nxt;
    end else if (redirect_en) begin
      r_pc        <= redirect_pc;
      r_id_inst   <= '0;
      r_id_pc     <= '0;
      r_id_pcp4   <= '0;
      r_id_valid  <= 1'b0;
      r_flush_cnt <= w_flush_nxt;
    end else begin
      r_pc       <= w_pc_p4;
      r_id_inst  <= inst_data;
      r_id_pc    <= r_pc;
      r_id_pcp4  <= w_pc_p4;
      r_id_valid <= 1'b1;
    end
  end
  assign inst_addr = r_pc;
  assign ID_inst   = r_id_inst;
  assign ID_pc     = r_id_pc;
  assign ID_pcp4   = r_id_pcp4;
  assign ID_valid  = r_id_valid;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb_if_id_fetch_stage: directed bench with a behavioural fetch model and literal pins.
module tb_if_id_fetch_stage;
  localparam int CW = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1, stall = 1'b0, redirect_en = 1'b0;
  logic [31:0]   redirect_pc = '0, inst_data, inst_addr;
  logic [31:0]   ID_inst, ID_pc, ID_pcp4;
  logic          ID_valid;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0, failures = 0;
  bit armed = 1'b0;
  logic [31:0] m_pc, m_inst, m_idpc, m_idpcp4;
  logic        m_valid;
  int          m_sc, m_fc;
  localparam int SAT = (1 << CW) - 1;

  if_id_fetch_stage #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_data(inst_data),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .ID_inst(ID_inst), .ID_pc(ID_pc), .ID_pcp4(ID_pcp4), .ID_valid(ID_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h2008_0005 : a == 32'h4 ? 32'h2009_0003 : (a ^ 32'hA5A5_0000) | 32'h1;
  endfunction
  assign inst_data = mem(inst_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the fetch stage must present, from the stage rules directly.
  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      m_pc = 32'h0; m_inst = 0; m_idpc = 0; m_idpcp4 = 0; m_valid = 0; m_sc = 0; m_fc = 0;
    end else if (armed) begin
      if (stall) m_sc = m_sc < SAT ? m_sc + 1 : SAT;
      else if (redirect_en) begin
        m_inst = 0; m_idpc = 0; m_idpcp4 = 0; m_valid = 0;
        m_fc = m_fc < SAT ? m_fc + 1 : SAT;
        m_pc = redirect_pc;
      end else begin
        m_inst = mem(m_pc); m_idpc = m_pc; m_idpcp4 = m_pc + 4; m_valid = 1;
        m_pc = m_pc + 4;
      end
    end
  end

  always @(negedge clk) if (armed) begin
    chk("inst_addr", inst_addr, m_pc);
    chk("ID_inst", ID_inst, m_inst);
    chk("ID_pc", ID_pc, m_idpc);
    chk("ID_pcp4", ID_pcp4, m_idpcp4);
    chk("ID_valid", {31'b0, ID_valid}, {31'b0, m_valid});
    chk("stall_cnt", {30'b0, stall_cnt}, m_sc);
    chk("flush_cnt", {30'b0, flush_cnt}, m_fc);
  end

  task automatic cyc(input logic r, input logic s, input logic re, input logic [31:0] rp);
    rst = r; stall = s; redirect_en = re; redirect_pc = rp;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_valid", {31'b0, ID_valid}, 32'h0);
    chk("rst_inst", ID_inst, 32'h0);
    cyc(0, 0, 0, 0);
    chk("t1_inst0", ID_inst, 32'h2008_0005);
    chk("t1_pc0", ID_pc, 32'h0);
    chk("t1_pcp4", ID_pcp4, 32'h4);
    chk("t1_valid", {31'b0, ID_valid}, 32'h1);
    cyc(0, 0, 0, 0);
    chk("t1_inst1", ID_inst, 32'h2009_0003);
    chk("t1_pc1", ID_pc, 32'h4);
    chk("t1_addr8", inst_addr, 32'h8);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t2_addr", inst_addr, 32'h8);
    chk("t2_inst", ID_inst, 32'h2009_0003);
    chk("t2_scnt", {30'b0, stall_cnt}, 32'd2);
    cyc(0, 0, 0, 0);
    chk("t2_pc8", ID_pc, 32'h8);
    chk("t2_addr12", inst_addr, 32'hC);
    cyc(0, 0, 1, 32'h40);
    chk("t3_addr", inst_addr, 32'h40);
    chk("t3_inst", ID_inst, 32'h0);
    chk("t3_valid", {31'b0, ID_valid}, 32'h0);
    chk("t3_fcnt", {30'b0, flush_cnt}, 32'd1);
    cyc(0, 0, 0, 0);
    chk("t3_pc40", ID_pc, 32'h40);
    cyc(0, 1, 1, 32'h80);
    chk("t4_addr", inst_addr, 32'h44);
    chk("t4_pc", ID_pc, 32'h40);
    chk("t4_fcnt", {30'b0, flush_cnt}, 32'd1);
    chk("t4_scnt", {30'b0, stall_cnt}, 32'd3);
    cyc(0, 0, 1, 32'h80);
    chk("t4_addr80", inst_addr, 32'h80);
    chk("t4_fcnt2", {30'b0, flush_cnt}, 32'd2);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    chk("t6_ssat", {30'b0, stall_cnt}, 32'd3);
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    chk("t6_fsat", {30'b0, flush_cnt}, 32'd3);
    cyc(0, 0, 0, 0);
    chk("t6_wrap_addr", inst_addr, 32'h0);
    chk("t6_wrap_pcp4", ID_pcp4, 32'h0);
    chk("t6_wrap_pc", ID_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 32'h80);
    chk("t5_addr", inst_addr, 32'h0);
    chk("t5_pc", ID_pc, 32'h0);
    chk("t5_scnt", {30'b0, stall_cnt}, 32'd0);
    chk("t5_fcnt", {30'b0, flush_cnt}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("t5_inst", ID_inst, 32'h2008_0005);
    chk("t5_addr4", inst_addr, 32'h4);
    cyc(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
